irq_controller: RTL
===================

# irq_controller

Bus-mapped interrupt controller between up to eight peripheral interrupt sources and the CPU's two-line raise/acknowledge interrupt interface. It sits on the shared 8-bit data/address bus alongside RAM and the VGA wrapper. It latches source rising edges into a pending register and applies a per-source mask and a per-source line route. One sequencer per CPU line holds that line's raise high until the CPU acknowledges it.

## Interface
- BASE_ADDR, 8'hE0: bus address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
- CLK  in  1  system clock; the block uses this single clock only.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; the block drives it only during its own read cycles, otherwise high-Z.
- BUS_ADDR  in  8  shared address bus.
- BUS_WE  in  1  bus write enable, 1 = write.
- IRQ_SRC  in  8  peripheral interrupt requests, synchronous to CLK, level.
- BUS_INTERRUPTS_RAISE  out  2  raise to CPU line 0 / line 1.
- BUS_INTERRUPTS_ACK  in  2  CPU acknowledge, one-cycle pulse per line.

## Operation
- Registers:
  - +0 PENDING: read, or write-1-to-clear.
  - +1 MASK: R/W, 1 = source enabled.
  - +2 ROUTE: R/W; bit i = 0 routes source i to line 0, 1 routes it to line 1.
  - +3 ACTIVE: read-only. [2:0] = last acknowledged source ID on line 0, [3] = line-0 valid, [6:4] = line-1 ID, [7] = line-1 valid.
- Edge detect: src_prev registers IRQ_SRC each cycle. PENDING[i] is set on IRQ_SRC[i] & ~src_prev[i].
- Eligible set for line L: PENDING & MASK & (ROUTE == L per bit). The selected source is the lowest index in that set.
- Per-line FSM with two states, IDLE and RAISE:
  - IDLE -> RAISE when the eligible set is non-empty. The selected ID is latched into sel_id[L].
  - RAISE -> IDLE when BUS_INTERRUPTS_ACK[L] = 1. On that edge: PENDING[sel_id[L]] is cleared, ACTIVE ID[L] = sel_id[L], and ACTIVE valid[L] = 1.
  - In RAISE, sel_id is frozen. Masking, rerouting or clearing the source does not drop the raise; only ACK ends it.
  - ACK while IDLE is ignored.
- BUS_INTERRUPTS_RAISE[L] = (state[L] == RAISE), registered.
- Register write (address in range, BUS_WE = 1): takes effect at that clock edge.
  - PENDING: bits written 1 are cleared.
  - Writes to ACTIVE are ignored.
- Register read (address in range, BUS_WE = 0): register contents are captured at that edge and driven on BUS_DATA for the following cycle. Otherwise BUS_DATA = 8'hZZ.
- Priority on the same PENDING bit in the same cycle: new edge set > ACK clear > write-1 clear. A set always wins.
- Both lines may raise and acknowledge independently in the same cycle. Their clears apply to different bits, because a source routes to exactly one line.

## Timing
- Reset (synchronous): PENDING, MASK, ROUTE, ACTIVE, src_prev and sel_id are 0. Both FSMs go to IDLE, RAISE = 2'b00, and the read driver is off (BUS_DATA = Z).
- Reset mid-RAISE drops the raise on the next edge; a subsequent ACK is ignored.
- A source held high through reset release sets PENDING on the first post-reset edge. MASK = 0, so it is not raised until enabled.
- Latency, source to raise: IRQ_SRC rises before edge k, PENDING is set at edge k, the FSM enters RAISE at edge k+1, and RAISE is visible after k+1 (2 cycles).
- Latency, ACK: ACK sampled at edge m drops RAISE after m. The next eligible source re-raises at edge m+1 at the earliest, so there is at least one low cycle between raises.
- Read latency: address at edge n, data valid on BUS_DATA from edge n through edge n+1.
- A MASK write enabling an already-pending source raises it 1 edge after the write edge.

## Test plan
- Reset, MASK = 8'h01, ROUTE = 0, pulse IRQ_SRC[0] -> PENDING = 8'h01, RAISE = 2'b01 two edges later. ACK[0] -> RAISE = 2'b00, PENDING = 8'h00, ACTIVE = 8'h08.
- MASK = 8'hFF, ROUTE = 8'hF0, pulse IRQ_SRC = 8'h24 in the same cycle -> RAISE = 2'b11. ACK both -> ACTIVE = 8'hDA, PENDING = 8'h00.
- MASK = 8'h0C, pulse sources 2 and 3 -> line 0 services 2 first. After ACK, RAISE is low one cycle and then re-raises for 3. Second ACK -> ACTIVE[2:0] = 3.
- Pending source with MASK = 0 -> no raise. Write MASK = 8'h02 with PENDING = 8'h02 -> RAISE[0] one edge later. Write PENDING = 8'h02 during RAISE -> raise held until ACK.
- Same cycle: new edge on source 1 and write PENDING = 8'h02 -> PENDING[1] stays 1. ACK with line IDLE -> no state change.
- Read each of +0..+3 -> data on BUS_DATA the next cycle only. A read at BASE_ADDR+4 and any cycle without a read -> BUS_DATA = Z. Assert RESET during RAISE -> RAISE = 0 after that edge.

Source files
------------

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller: edge-latched pending bits, per-source mask and line route,
// and one raise/acknowledge sequencer per CPU interrupt line.
module irq_controller #(
   parameter logic [7:0] BASE_ADDR = 8'hE0
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [7:0] IRQ_SRC,
   output logic [1:0] BUS_INTERRUPTS_RAISE,
   input  logic [1:0] BUS_INTERRUPTS_ACK,
   output logic [1:0] o_dbg_state
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_RAISE = 1'b1
   } line_state_t;

   localparam logic [1:0] OFS_PENDING = 2'd0;
   localparam logic [1:0] OFS_MASK    = 2'd1;
   localparam logic [1:0] OFS_ROUTE   = 2'd2;
   localparam logic [1:0] OFS_ACTIVE  = 2'd3;

   logic [7:0]  r_src_prev;
   logic [7:0]  r_pending;
   logic [7:0]  r_mask;
   logic [7:0]  r_route;
   logic [7:0]  r_active;
   logic [7:0]  r_rd_data;
   logic        r_rd_en;
   line_state_t r_state [2];
   logic [2:0]  r_sel_id [2];

   line_state_t w_state_nxt [2];
   logic [2:0]  w_sel_nxt [2];
   logic [1:0]  w_ack_take;
   logic [7:0]  w_elig [2];
   logic [7:0]  w_edge;
   logic [7:0]  w_offset;
   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic [7:0]  w_wr_clr;
   logic [7:0]  w_ack_clr;
   logic [7:0]  w_pend_nxt;
   logic [7:0]  w_active_nxt;
   logic [7:0]  w_rd_mux;

   function automatic logic [2:0] f_lowest(input logic [7:0] set);
      logic [2:0] id;
      id = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (set[i]) id = i[2:0];
      end
      return id;
   endfunction

   // Unsigned wrap of the offset makes a single compare cover the 4-register window.
   assign w_offset = BUS_ADDR - BASE_ADDR;
   assign w_hit    = (w_offset < 8'd4);
   assign w_wr     = w_hit & BUS_WE;
   assign w_rd     = w_hit & ~BUS_WE;

   assign w_edge    = IRQ_SRC & ~r_src_prev;
   assign w_elig[0] = r_pending & r_mask & ~r_route;
   assign w_elig[1] = r_pending & r_mask & r_route;

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         w_state_nxt[l] = r_state[l];
         w_sel_nxt[l]   = r_sel_id[l];
         w_ack_take[l]  = 1'b0;
         case (r_state[l])
            ST_IDLE: begin
               if (|w_elig[l]) begin
                  w_state_nxt[l] = ST_RAISE;
                  w_sel_nxt[l]   = f_lowest(w_elig[l]);
               end
            end
            ST_RAISE: begin
               // Only the acknowledge ends a raise; the latched ID stays frozen meanwhile.
               if (BUS_INTERRUPTS_ACK[l]) begin
                  w_state_nxt[l] = ST_IDLE;
                  w_ack_take[l]  = 1'b1;
               end
            end
            default: w_state_nxt[l] = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_wr_clr = 8'h00;
      if (w_wr && (w_offset[1:0] == OFS_PENDING)) w_wr_clr = BUS_DATA;
      w_ack_clr = 8'h00;
      if (w_ack_take[0]) w_ack_clr = w_ack_clr | (8'd1 << r_sel_id[0]);
      if (w_ack_take[1]) w_ack_clr = w_ack_clr | (8'd1 << r_sel_id[1]);
      // A fresh edge beats both kinds of clear on the same bit.
      w_pend_nxt = (r_pending & ~w_ack_clr & ~w_wr_clr) | w_edge;
   end

   always_comb begin
      w_active_nxt = r_active;
      if (w_ack_take[0]) w_active_nxt[3:0] = {1'b1, r_sel_id[0]};
      if (w_ack_take[1]) w_active_nxt[7:4] = {1'b1, r_sel_id[1]};
   end

   always_comb begin
      w_rd_mux = 8'h00;
      case (w_offset[1:0])
         OFS_PENDING: w_rd_mux = r_pending;
         OFS_MASK:    w_rd_mux = r_mask;
         OFS_ROUTE:   w_rd_mux = r_route;
         OFS_ACTIVE:  w_rd_mux = r_active;
         default:     w_rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state[0]  <= ST_IDLE;
         r_state[1]  <= ST_IDLE;
         r_sel_id[0] <= 3'd0;
         r_sel_id[1] <= 3'd0;
      end else begin
         r_state[0]  <= w_state_nxt[0];
         r_state[1]  <= w_state_nxt[1];
         r_sel_id[0] <= w_sel_nxt[0];
         r_sel_id[1] <= w_sel_nxt[1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_src_prev <= 8'h00;
         r_pending  <= 8'h00;
         r_mask     <= 8'h00;
         r_route    <= 8'h00;
         r_active   <= 8'h00;
         r_rd_en    <= 1'b0;
         r_rd_data  <= 8'h00;
      end else begin
         r_src_prev <= IRQ_SRC;
         r_pending  <= w_pend_nxt;
         r_active   <= w_active_nxt;
         if (w_wr && (w_offset[1:0] == OFS_MASK))  r_mask  <= BUS_DATA;
         if (w_wr && (w_offset[1:0] == OFS_ROUTE)) r_route <= BUS_DATA;
         r_rd_en <= w_rd;
         if (w_rd) r_rd_data <= w_rd_mux;
      end
   end

   assign BUS_DATA = r_rd_en ? r_rd_data : 8'hzz;

   assign BUS_INTERRUPTS_RAISE = {r_state[1] == ST_RAISE, r_state[0] == ST_RAISE};
   assign o_dbg_state          = {r_state[1], r_state[0]};

endmodule
